// File: rtl/kf8253_config_sequencer.sv
// Bus master for the KF8253 CPU port: programs counters after reset, then serves host accesses.
// Optional 16-bit latched counter read is enabled by defining KF8253_CFG_LATCH_READ_EN.
module kf8253_config_sequencer #(
    parameter int unsigned  STROBE_CYCLES = 2,
    parameter logic [2:0]   CNT_EN        = 3'b111,
    parameter logic [2:0]   CNT0_MODE     = 3'd3,
    parameter logic [15:0]  CNT0_DIV      = 16'h0000,
    parameter logic [2:0]   CNT1_MODE     = 3'd2,
    parameter logic [15:0]  CNT1_DIV      = 16'd18,
    parameter logic [2:0]   CNT2_MODE     = 3'd3,
    parameter logic [15:0]  CNT2_DIV      = 16'd1331
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [1:0]  host_addr,
    input  logic [7:0]  host_wdata,
`ifdef KF8253_CFG_LATCH_READ_EN
    input  logic        host_rd16,
    output logic [15:0] host_rdata16,
`endif
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        init_busy,
    output logic        pit_chip_select_n,
    output logic        pit_read_enable_n,
    output logic        pit_write_enable_n,
    output logic [1:0]  pit_address,
    output logic [7:0]  pit_data_out,
    input  logic [7:0]  pit_data_in
);
    typedef enum logic [2:0] {INIT_NEXT, SETUP, STROBE, HOLD, IDLE} state_t;

    localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);

    // Lowest enabled counter at or above 'from'; 3 means none left.
    function automatic logic [1:0] first_en(input int from);
        first_en = 2'd3;
        for (int i = 0; i < 3; i++)
            if (i >= from && CNT_EN[i] && first_en == 2'd3) first_en = i[1:0];
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] c, input logic [1:0] b);
        logic [2:0]  mode;
        logic [15:0] div;
        case (c)
            2'd0:    begin mode = CNT0_MODE; div = CNT0_DIV; end
            2'd1:    begin mode = CNT1_MODE; div = CNT1_DIV; end
            default: begin mode = CNT2_MODE; div = CNT2_DIV; end
        endcase
        case (b)
            2'd0:    init_byte = {c, 2'b11, mode, 1'b0};
            2'd1:    init_byte = div[7:0];
            default: init_byte = div[15:8];
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d, byte_q, byte_d, nxt_cnt;
    logic        busy_q, busy_d, we_q, we_d, ack_q, ack_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d, rbyte_q, rbyte_d, rdata_q, rdata_d;
    logic [3:0]  stb_q, stb_d;
    logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
`ifdef KF8253_CFG_LATCH_READ_EN
    logic        rd16_q, rd16_d;
    logic [1:0]  seq_q, seq_d, haddr_q, haddr_d;
    logic [7:0]  lsb_q, lsb_d;
    logic [15:0] rdata16_q, rdata16_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        busy_d  = busy_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        stb_d   = stb_q;
        rbyte_d = rbyte_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        nxt_cnt = 2'd3;
`ifdef KF8253_CFG_LATCH_READ_EN
        rd16_d    = rd16_q;
        seq_d     = seq_q;
        haddr_d   = haddr_q;
        lsb_d     = lsb_q;
        rdata16_d = rdata16_q;
`endif
        case (state_q)
            INIT_NEXT: begin
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = (byte_q == 2'd0) ? 2'd3 : cnt_q;
                    data_d  = init_byte(cnt_q, byte_q);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                stb_d   = STB_LAST;
                state_d = STROBE;
            end
            STROBE: begin
                if (stb_q == 4'd0) begin
                    if (!we_q) rbyte_d = pit_data_in;
                    state_d = HOLD;
                end else begin
                    stb_d = stb_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                if (busy_q) begin
                    // Leaving HOLD straight to IDLE on the last item drops init_busy one cycle after it.
                    state_d = INIT_NEXT;
                    if (byte_q == 2'd2) begin
                        nxt_cnt = first_en(int'(cnt_q) + 1);
                        cnt_d   = nxt_cnt;
                        byte_d  = 2'd0;
                        if (nxt_cnt == 2'd3) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        byte_d = byte_q + 2'd1;
                    end
`ifdef KF8253_CFG_LATCH_READ_EN
                end else if (rd16_q && seq_q != 2'd2) begin
                    seq_d = seq_q + 2'd1;
                    if (seq_q == 2'd1) lsb_d = rbyte_q;
`endif
                end else begin
                    ack_d = 1'b1;
                    if (!we_q) rdata_d = rbyte_q;
`ifdef KF8253_CFG_LATCH_READ_EN
                    if (rd16_q) rdata16_d = {rbyte_q, lsb_q};
                    rd16_d = 1'b0;
`endif
                end
            end
            IDLE: begin
`ifdef KF8253_CFG_LATCH_READ_EN
                if (rd16_q) begin
                    we_d    = 1'b0;
                    addr_d  = haddr_q;
                    state_d = SETUP;
                end else if (host_req && !ack_q) begin
                    if (host_rd16 && !host_we) begin
                        rd16_d  = 1'b1;
                        seq_d   = 2'd0;
                        haddr_d = host_addr;
                        we_d    = 1'b1;
                        addr_d  = 2'd3;
                        data_d  = {host_addr, 6'b000000};
                    end else begin
                        we_d   = host_we;
                        addr_d = host_addr;
                        data_d = host_wdata;
                    end
                    state_d = SETUP;
                end
`else
                // The ack cycle doubles as the mandatory idle gap, so a held request waits one cycle.
                if (host_req && !ack_q) begin
                    we_d    = host_we;
                    addr_d  = host_addr;
                    data_d  = host_wdata;
                    state_d = SETUP;
                end
`endif
            end
            default: state_d = INIT_NEXT;
        endcase
        cs_n_d = !(state_d inside {SETUP, STROBE, HOLD});
        wr_n_d = !(state_d == STROBE && we_d);
        rd_n_d = !(state_d == STROBE && !we_d);
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q <= INIT_NEXT;
            cnt_q   <= first_en(0);
            byte_q  <= 2'd0;
            busy_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 2'd0;
            data_q  <= 8'd0;
            stb_q   <= 4'd0;
            rbyte_q <= 8'd0;
            rdata_q <= 8'd0;
            ack_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            rbyte_q <= rbyte_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

`ifdef KF8253_CFG_LATCH_READ_EN
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            rd16_q    <= 1'b0;
            seq_q     <= 2'd0;
            haddr_q   <= 2'd0;
            lsb_q     <= 8'd0;
            rdata16_q <= 16'd0;
        end else begin
            rd16_q    <= rd16_d;
            seq_q     <= seq_d;
            haddr_q   <= haddr_d;
            lsb_q     <= lsb_d;
            rdata16_q <= rdata16_d;
        end
    end
    assign host_rdata16 = rdata16_q;
`endif

    assign host_ack           = ack_q;
    assign host_rdata         = rdata_q;
    assign init_busy          = busy_q;
    assign pit_chip_select_n  = cs_n_q;
    assign pit_read_enable_n  = rd_n_q;
    assign pit_write_enable_n = wr_n_q;
    assign pit_address        = addr_q;
    assign pit_data_out       = data_q;
endmodule

// File: tb/tb_kf8253_config_sequencer.sv
// Directed bench for kf8253_config_sequencer: bus accesses are checked against a queue of expected transfers.
module tb_kf8253_config_sequencer;
    localparam int SC = 2;

    logic clk = 1'b0, rst = 1'b0, rst2 = 1'b0;
    always #5 clk = ~clk;

    logic       host_req = 1'b0, host_we = 1'b0;
    logic [1:0] host_addr = 2'd0;
    logic [7:0] host_wdata = 8'd0;
    logic       host_ack, init_busy, cs_n, rd_n, wr_n;
    logic [7:0] host_rdata, pdo, pdi;
    logic [1:0] paddr;

    logic       req2 = 1'b0;
    logic [7:0] pdi2 = 8'h00;
    logic       ack2, busy2, cs2, rd2, wr2;
    logic [7:0] rdata2, pdo2;
    logic [1:0] paddr2;
`ifdef KF8253_CFG_LATCH_READ_EN
    logic        host_rd16 = 1'b0, rd16_2 = 1'b0;
    logic [15:0] host_rdata16, rdata16_2;
`endif

    logic [9:0] wq[$], wq2[$];
    logic [1:0] rq[$];
    logic [7:0] rdq[$];
    logic [7:0] cur_rd = 8'h00;
    logic [9:0] init_exp [0:8];
    int checks = 0, errors = 0, cyc = 0, last_cs = 0;

    assign pdi = rd_n ? 8'hFF : cur_rd;

    kf8253_config_sequencer #(.STROBE_CYCLES(SC)) dut (
        .clock(clk), .reset_in(rst), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
`ifdef KF8253_CFG_LATCH_READ_EN
        .host_rd16(host_rd16), .host_rdata16(host_rdata16),
`endif
        .host_ack(host_ack), .host_rdata(host_rdata), .init_busy(init_busy),
        .pit_chip_select_n(cs_n), .pit_read_enable_n(rd_n), .pit_write_enable_n(wr_n),
        .pit_address(paddr), .pit_data_out(pdo), .pit_data_in(pdi));

    kf8253_config_sequencer #(.STROBE_CYCLES(SC), .CNT_EN(3'b010)) dut2 (
        .clock(clk), .reset_in(rst2), .host_req(req2), .host_we(1'b1),
        .host_addr(2'd0), .host_wdata(8'h77),
`ifdef KF8253_CFG_LATCH_READ_EN
        .host_rd16(rd16_2), .host_rdata16(rdata16_2),
`endif
        .host_ack(ack2), .host_rdata(rdata2), .init_busy(busy2),
        .pit_chip_select_n(cs2), .pit_read_enable_n(rd2), .pit_write_enable_n(wr2),
        .pit_address(paddr2), .pit_data_out(pdo2), .pit_data_in(pdi2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor for the main instance: order, content and strobe width of every access.
    logic wr_prev = 1'b1, rd_prev = 1'b1;
    int   wlen = 0, rlen = 0;
    always @(negedge clk) begin
        if (rst) begin
            wr_prev = 1'b1; rd_prev = 1'b1; wlen = 0; rlen = 0;
        end else begin
            if (!cs_n) last_cs = cyc;
            if (!wr_n || !rd_n) begin
                chk("strobe_overlap", wr_n | rd_n, 1);
                chk("cs_during_strobe", cs_n, 0);
            end
            if (!wr_n) begin
                if (wr_prev) begin
                    chk("wr_pending", wq.size() != 0, 1);
                    if (wq.size() != 0) chk("wr_addr_data", {paddr, pdo}, wq.pop_front());
                end
                wlen++;
            end else if (!wr_prev) begin
                chk("wr_width", wlen, SC);
                wlen = 0;
            end
            if (!rd_n) begin
                if (rd_prev) begin
                    chk("rd_pending", rq.size() != 0, 1);
                    if (rq.size() != 0) chk("rd_addr", paddr, rq.pop_front());
                    if (rdq.size() != 0) cur_rd = rdq.pop_front();
                end
                rlen++;
            end else if (!rd_prev) begin
                chk("rd_width", rlen, SC);
                rlen = 0;
            end
            wr_prev = wr_n;
            rd_prev = rd_n;
        end
    end

    logic wr2_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst2) begin
            if (!wr2 && wr2_prev) begin
                chk("dut2_rd_idle", rd2, 1);
                chk("dut2_cs", cs2, 0);
                chk("dut2_wr_pending", wq2.size() != 0, 1);
                if (wq2.size() != 0) chk("dut2_wr_addr_data", {paddr2, pdo2}, wq2.pop_front());
            end
            wr2_prev = wr2;
        end
    end

    task automatic wait_ack(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (host_ack) begin at = cyc; break; end
        end
        chk("ack_timeout", at >= 0, 1);
    endtask

    task automatic wait_init(input string tag);
        int done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!init_busy) begin done = 1; break; end
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int n, t, seen;
        init_exp = '{{2'd3, 8'h36}, {2'd0, 8'h00}, {2'd0, 8'h00},
                     {2'd3, 8'h74}, {2'd1, 8'h12}, {2'd1, 8'h00},
                     {2'd3, 8'hB6}, {2'd2, 8'h33}, {2'd2, 8'h05}};
        #1 rst = 1'b1; rst2 = 1'b1;
        @(negedge clk);
        chk("rst_busy", init_busy, 1);
        chk("rst_ack", host_ack, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_strobes", {cs_n, rd_n, wr_n}, 3'b111);
        chk("rst_addr_data", {paddr, pdo}, 10'd0);

        foreach (init_exp[i]) wq.push_back(init_exp[i]);
        wq2.push_back({2'd3, 8'h74}); wq2.push_back({2'd1, 8'h12});
        wq2.push_back({2'd1, 8'h00}); wq2.push_back({2'd0, 8'h77});
        req2 = 1'b1;
        @(posedge clk); #1 rst = 1'b0; rst2 = 1'b0;

        // Request held from reset on the partial-init instance.
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack2) begin seen = 1; break; end
        end
        chk("dut2_ack_seen", seen, 1);
        chk("dut2_busy_at_ack", busy2, 0);
        chk("dut2_rdata", rdata2, 0);
        chk("dut2_all_writes", wq2.size(), 0);
        @(posedge clk); #1 req2 = 1'b0;

        wait_init("init_timeout");
        chk("busy_fall", cyc, last_cs + 1);
        chk("init_all_writes", wq.size(), 0);

        // Host write: latency from request sampling to ack.
        @(posedge clk); #1;
        wq.push_back({2'd2, 8'hA5});
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd2; host_wdata = 8'hA5; n = cyc;
        wait_ack(t);
        chk("wr_latency", t - n, 3 + SC);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", host_ack, 0);
        chk("wr_done", wq.size(), 0);

        // Host read.
        @(posedge clk); #1;
        rq.push_back(2'd1); rdq.push_back(8'h5A);
        host_req = 1'b1; host_we = 1'b0; host_addr = 2'd1; n = cyc;
        wait_ack(t);
        chk("rd_latency", t - n, 3 + SC);
        chk("rd_data", host_rdata, 8'h5A);
        chk("rd_done", rq.size(), 0);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        chk("rd_data_held", host_rdata, 8'h5A);

        // Request left high is served again after the one-cycle gap.
        @(posedge clk); #1;
        wq.push_back({2'd0, 8'h11}); wq.push_back({2'd0, 8'h11});
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd0; host_wdata = 8'h11;
        wait_ack(n);
        wait_ack(t);
        chk("rereq_spacing", t - n, 4 + SC);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        chk("rereq_done", wq.size(), 0);

        // Restart init, then reset it during the 4th write strobe.
        @(posedge clk); #1 rst = 1'b1;
        foreach (init_exp[i]) wq.push_back(init_exp[i]);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (wq.size() == 5) begin seen = 1; break; end
        end
        chk("reach_4th_write", seen, 1);
        chk("mid_strobe", wr_n, 0);
        rst = 1'b1;
        #1;
        chk("rst_abort_strobes", {cs_n, rd_n, wr_n}, 3'b111);
        chk("rst_abort_ack", host_ack, 0);
        wq.delete();
        foreach (init_exp[i]) wq.push_back(init_exp[i]);
        @(posedge clk); #1 rst = 1'b0;
        wait_init("reinit_timeout");
        chk("reinit_all_writes", wq.size(), 0);
        chk("reinit_no_ack", host_ack, 0);

`ifdef KF8253_CFG_LATCH_READ_EN
        @(posedge clk); #1;
        wq.push_back({2'd3, 8'h80});
        rq.push_back(2'd2); rq.push_back(2'd2);
        rdq.push_back(8'h34); rdq.push_back(8'h12);
        host_req = 1'b1; host_we = 1'b0; host_rd16 = 1'b1; host_addr = 2'd2;
        wait_ack(t);
        chk("rd16_data16", host_rdata16, 16'h1234);
        chk("rd16_data", host_rdata, 8'h12);
        chk("rd16_bus_done", wq.size() + rq.size(), 0);
        @(posedge clk); #1 host_req = 1'b0; host_rd16 = 1'b0;
        @(negedge clk);
        chk("rd16_single_ack", host_ack, 0);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
